irq_controller: RTL and testbench
=================================

# irq_controller

Multi-channel interrupt front end for the TramelBlaze, replacing the single-button debounce / posedge-detect / RS-flop chain. Accepts `CHANNELS` raw asynchronous button inputs, debounces and edge-detects each, latches events as pending bits, and raises one interrupt at a time with the selected channel number on a 16-bit vector port. The block sits between the board inputs and the processor's `INTERRUPT`/`INTERRUPT_ACK` pins; the vector feeds the processor input-port mux.

## Interface
- `CHANNELS`, 4: number of interrupt sources, 1..16.
- `DB_CYCLES`, 2000000: clock cycles of stable input required before accepting a level change (20 ms at 100 MHz).
- `VEC_W`, 16: vector/port width.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low (0 = reset); one clock domain.
- `btn`  in  CHANNELS  raw button levels, asynchronous to `clk`.
- `int_ack`  in  1  processor interrupt-acknowledge pulse.
- `mask_ld`  in  1  load `mask_din` into the mask register.
- `mask_din`  in  CHANNELS  new mask; 1 = channel disabled.
- `interrupt`  out  1  to processor `INTERRUPT`.
- `vector`  out  VEC_W  zero-extended index of the channel being serviced.
- `pending`  out  CHANNELS  pending bits, for status reads.
- `overrun`  out  CHANNELS  sticky: event arrived while the channel was already pending.

## Operation
- Per channel: 2-flop synchronizer -> debouncer -> rising-edge detect on the debounced level.
- Debouncer: `stable` register, counter of width $clog2(DB_CYCLES+1). Sync equals `stable` -> counter = 0. Differs -> counter increments; once it reaches DB_CYCLES-1 with input still differing, `stable` takes the sync value and counter clears. Any glitch shorter than DB_CYCLES cycles is ignored.
- Debounced 0->1 sets `pending[i]`. If `pending[i]` already 1, set `overrun[i]` instead.
- `eligible = pending & ~mask`. Masked channels still latch pending but never interrupt.
- FSM states: IDLE, ASSERT, GAP.
  - IDLE: `eligible` != 0 -> latch winner index into `vector`, `interrupt` = 1, go ASSERT.
  - ASSERT: hold `interrupt` and `vector`; on `int_ack`, clear `pending[vector]` and `overrun[vector]`, `interrupt` = 0, go GAP. Masking the serviced channel mid-ASSERT does not withdraw the interrupt.
  - GAP: one cycle, go IDLE (guarantees `interrupt` low at least one cycle between requests).
- Winner selection: lowest-index eligible channel (fixed priority).
- Same-cycle edge on channel `vector` and `int_ack`: set wins; `pending` stays 1 and is serviced again later; `overrun` cleared.
- `int_ack` outside ASSERT is ignored.
- `mask_ld` takes effect the following cycle.

## Timing
- Reset values: `interrupt` 0, `vector` 0, `pending` 0, `overrun` 0, mask 0 (all enabled), debounced levels 0, counters 0, FSM IDLE.
- Raw press to `pending` set: 2 (sync) + DB_CYCLES + 1 cycles; `pending` to `interrupt` high: 1 cycle.
- `int_ack` to `interrupt` low: 1 cycle; earliest next `interrupt`: 3 cycles after `int_ack`.
- Reset assertion mid-ASSERT: all state clears asynchronously; the in-flight event is lost.
- All outputs registered.

## Configuration
- `IRQ_ROUND_ROBIN_EN` defined: rotating priority; search starts at (last serviced index + 1) mod CHANNELS; pointer resets to 0 so first search starts at channel 0... wraps.
- Undefined: fixed lowest-index priority; no pointer register.

## Structure
- Package `irq_pkg`: FSM state encoding (IDLE, ASSERT, GAP), clog2 helper, vector zero-extension width constant.
- Sub-module `db_chan`: synchronizer, debouncer and edge detect for one channel, parameter DB_CYCLES, outputs one-cycle `rise` pulse; instantiated CHANNELS times via generate.

## Test plan
- Bench uses DB_CYCLES = 4, CHANNELS = 4.
- Glitch: `btn[1]` high 3 cycles then low -> `pending` stays 4'b0000, `interrupt` never rises.
- Single press: `btn[2]` high 10 cycles -> `pending` = 4'b0100 at cycle 7, `interrupt` = 1 and `vector` = 16'h0002 at cycle 8; `int_ack` -> `interrupt` 0 next cycle, `pending` 4'b0000.
- Priority: channels 3 and 0 pending together -> vector 16'h0000 served first, then 16'h0003 after GAP; with `IRQ_ROUND_ROBIN_EN` and last served = 0, pending {0,3} -> 16'h0003 first.
- Mask: `mask_din` = 4'b0010 loaded, press channel 1 -> `pending[1]` = 1, no interrupt; load mask 0 -> interrupt with vector 16'h0001 two cycles later.
- Overrun and collision: second debounced press on channel 2 while pending -> `overrun` = 4'b0100; edge coincident with `int_ack` -> `pending[2]` remains 1, `overrun[2]` 0, re-interrupt after GAP.
- Reset mid-ASSERT: drive `reset` 0 while `interrupt` = 1 -> all outputs 0 immediately, no interrupt after release until a new press.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and helpers for the irq_controller block: FSM encoding,
// ceiling-log2 helper and the default vector port width.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } irq_state_e;

  localparam int VEC_W_DEFAULT = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Processor-side port bundle of irq_controller: interrupt request/ack,
// vector, mask load and status, plus the FSM state for debug.
interface irq_controller_if
  import irq_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int VEC_W    = VEC_W_DEFAULT
);

  // interrupt is a level request: once raised it holds, with vector stable,
  // until a one-cycle int_ack is sampled; int_ack at any other time is ignored.
  logic                int_ack;
  logic                mask_ld;
  logic [CHANNELS-1:0] mask_din;
  logic                interrupt;
  logic [VEC_W-1:0]    vector;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] overrun;
  irq_state_e          state;

  modport master (
    output int_ack, mask_ld, mask_din,
    input  interrupt, vector, pending, overrun, state
  );

  modport slave (
    input  int_ack, mask_ld, mask_din,
    output interrupt, vector, pending, overrun, state
  );

endinterface

// File: rtl/irq_controller_db_chan.sv
// One input channel: 2-flop synchronizer, counter debouncer and a registered
// one-cycle pulse on each accepted 0->1 transition of the debounced level.
module db_chan
  import irq_pkg::*;
#(
  parameter int DB_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = (clog2(DB_CYCLES + 1) > 0) ? clog2(DB_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      rise   <= 1'b0;
      if (sync_q[1] == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Input has differed for DB_CYCLES consecutive cycles: accept it.
        stable <= sync_q[1];
        cnt    <= '0;
        rise   <= sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Multi-channel interrupt front end: debounced edge events latch into pending
// bits and are presented one at a time. Define IRQ_ROUND_ROBIN_EN for rotating priority.
module irq_controller
  import irq_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DB_CYCLES = 2000000,
  parameter int VEC_W     = VEC_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn,
  irq_controller_if.slave     bus
);

  localparam int IDX_W = (CHANNELS > 1) ? clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] mask;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] overrun;
  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] clr;
  logic [IDX_W-1:0]    svc_idx;
  logic [IDX_W-1:0]    win_idx;
  logic                interrupt;
  logic                grant;
  irq_state_e          state;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    db_chan #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[g]),
      .rise  (rise[g])
    );
  end

  assign eligible = pending & ~mask;
  assign grant    = (state == IDLE) && (|eligible);

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    int  k;
    logic found;
    k       = 0;
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= CHANNELS) k = k - CHANNELS;
      if (!found && eligible[k]) begin
        win_idx = IDX_W'(k);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (win_idx == IDX_W'(CHANNELS - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    clr = '0;
    if (state == ASSERT && bus.int_ack) clr[svc_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask      <= '0;
      pending   <= '0;
      overrun   <= '0;
      svc_idx   <= '0;
      interrupt <= 1'b0;
      state     <= IDLE;
    end else begin
      if (bus.mask_ld) mask <= bus.mask_din;
      // A new edge on the channel being acknowledged wins over the clear;
      // its overrun bit is still cleared because the old event was serviced.
      pending <= (pending & ~clr) | rise;
      overrun <= (overrun | (rise & pending)) & ~clr;
      case (state)
        IDLE: begin
          if (grant) begin
            svc_idx   <= win_idx;
            interrupt <= 1'b1;
            state     <= ASSERT;
          end
        end
        ASSERT: begin
          if (bus.int_ack) begin
            interrupt <= 1'b0;
            state     <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.interrupt = interrupt;
  assign bus.vector    = VEC_W'(svc_idx);
  assign bus.pending   = pending;
  assign bus.overrun   = overrun;
  assign bus.state     = state;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with CHANNELS=4, DB_CYCLES=4; every
// rising interrupt is matched against a queue of expected vectors.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int CH = 4;
  localparam int DB = 4;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] btn;

  irq_controller_if #(.CHANNELS(CH), .VEC_W(VW)) bus ();

  irq_controller #(.CHANNELS(CH), .DB_CYCLES(DB), .VEC_W(VW)) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .bus   (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] mon_exp;
  logic          prev_int = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every new interrupt request must match the next expected vector
  always @(negedge clk) begin
    if (!reset) begin
      prev_int <= 1'b0;
    end else begin
      if (bus.interrupt && !prev_int) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_irq: got vector %0h expected no interrupt", bus.vector);
        end else begin
          mon_exp = exp_q.pop_front();
          check("irq_vector", bus.vector, mon_exp);
        end
      end
      prev_int <= bus.interrupt;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_int(input string name);
    int n;
    n = 0;
    while (!bus.interrupt && n < 60) begin
      tick();
      n++;
    end
    check(name, bus.interrupt, 1);
  endtask

  task automatic serve(input int ch);
    wait_int($sformatf("serve%0d_wait", ch));
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check("ack_int_low", bus.interrupt, 0);
    check("ack_pending_clr", bus.pending[ch], 0);
    check("ack_overrun_clr", bus.overrun[ch], 0);
    tick();
    check("gap_int_low", bus.interrupt, 0);
  endtask

  task automatic press(input int ch, input int hold);
    btn[ch] = 1'b1;
    repeat (hold) tick();
    btn[ch] = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    reset        = 1'b0;
    btn          = '0;
    bus.int_ack  = 1'b0;
    bus.mask_ld  = 1'b0;
    bus.mask_din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_interrupt", bus.interrupt, 0);
    check("rst_vector", bus.vector, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    reset = 1'b1;
    tick();

    // glitch shorter than the debounce window
    btn[1] = 1'b1;
    repeat (3) tick();
    btn[1] = 1'b0;
    repeat (12) tick();
    check("glitch_pending", bus.pending, 0);
    check("glitch_int", bus.interrupt, 0);

    // single press latency
    exp_q.push_back(16'h0002);
    btn[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) check("press_pending_early", bus.pending, 4'b0000);
      if (k == 7) begin
        check("press_pending", bus.pending, 4'b0100);
        check("press_int_early", bus.interrupt, 0);
      end
      if (k == 8) begin
        check("press_int", bus.interrupt, 1);
        check("press_vector", bus.vector, 16'h0002);
      end
    end
    btn[2] = 1'b0;
    serve(2);
    check("press_pending_after", bus.pending, 0);
    repeat (12) tick();

    // two channels pending at once
`ifdef IRQ_ROUND_ROBIN_EN
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0000);
`else
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0003);
`endif
    btn[0] = 1'b1;
    btn[3] = 1'b1;
    repeat (8) tick();
    check("prio_pending", bus.pending, 4'b1001);
    check("prio_int", bus.interrupt, 1);
    btn[0] = 1'b0;
    btn[3] = 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
    serve(3);
`else
    serve(0);
`endif
    tick();
    check("gap_reint", bus.interrupt, 1);
`ifdef IRQ_ROUND_ROBIN_EN
    serve(0);
`else
    serve(3);
`endif
    check("prio_pending_after", bus.pending, 0);
    repeat (12) tick();

    // masked channel latches but does not interrupt
    bus.mask_din = 4'b0010;
    bus.mask_ld  = 1'b1;
    tick();
    bus.mask_ld  = 1'b0;
    press(1, 8);
    check("mask_pending", bus.pending, 4'b0010);
    check("mask_int", bus.interrupt, 0);
    exp_q.push_back(16'h0001);
    bus.mask_din = 4'b0000;
    bus.mask_ld  = 1'b1;
    tick();
    bus.mask_ld  = 1'b0;
    check("unmask_int_low", bus.interrupt, 0);
    tick();
    check("unmask_int", bus.interrupt, 1);
    check("unmask_vector", bus.vector, 16'h0001);
    serve(1);

    // second event while pending sets overrun
    exp_q.push_back(16'h0002);
    press(2, 8);
    check("ovr_int", bus.interrupt, 1);
    check("ovr_overrun_before", bus.overrun, 0);
    press(2, 8);
    check("ovr_overrun", bus.overrun, 4'b0100);
    check("ovr_pending", bus.pending, 4'b0100);
    serve(2);

    // edge coincident with int_ack: set wins, overrun cleared
    exp_q.push_back(16'h0002);
    press(2, 8);
    check("col_int", bus.interrupt, 1);
    exp_q.push_back(16'h0002);
    btn[2] = 1'b1;
    repeat (6) tick();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check("col_pending", bus.pending, 4'b0100);
    check("col_overrun", bus.overrun, 0);
    check("col_int_low", bus.interrupt, 0);
    repeat (2) tick();
    check("col_reint", bus.interrupt, 1);
    btn[2] = 1'b0;
    serve(2);
    repeat (12) tick();

    // reset while an interrupt is asserted
    exp_q.push_back(16'h0000);
    btn[0] = 1'b1;
    wait_int("rst_wait");
    btn[0] = 1'b0;
    repeat (2) tick();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_int", bus.interrupt, 0);
    check("midrst_vector", bus.vector, 0);
    check("midrst_pending", bus.pending, 0);
    check("midrst_overrun", bus.overrun, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) tick();
    check("postrst_int", bus.interrupt, 0);
    check("postrst_pending", bus.pending, 0);

    // recovery with a fresh press
    exp_q.push_back(16'h0001);
    press(1, 8);
    serve(1);

    repeat (2) tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
